// File: rtl/dffram_pkg.sv
// Shared types and elaboration helpers for the DFFRAM request controller.
package dffram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RD_WAIT,
    RSP
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Word address width for a RAM built from `banks` 16-word banks.
  function automatic int calc_awidth(input int banks);
    return $clog2(banks) + 4;
  endfunction

endpackage

// File: rtl/dffram_req_ctrl.sv
// Initiator-side sequencer for a single-port DFFRAM: turns valid/ready commands
// into EN0/WE0/A0/Di0 pin activity and returns read data on a valid/ready channel.
module dffram_req_ctrl
  import dffram_pkg::*;
#(
  parameter  int WSIZE  = 4,
  parameter  int BANKS  = 8,
  parameter  int RD_LAT = 1,
  localparam int AWIDTH = calc_awidth(BANKS)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [WSIZE-1:0]     cmd_mask,
  input  logic [AWIDTH-1:0]    cmd_addr,
  input  logic [WSIZE*8-1:0]   cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WSIZE*8-1:0]   rsp_rdata,
  output logic                 EN0,
  output logic [WSIZE-1:0]     WE0,
  output logic [AWIDTH-1:0]    A0,
  output logic [WSIZE*8-1:0]   Di0,
  input  logic [WSIZE*8-1:0]   Do0
);

  // Out-of-range latencies are clamped to the supported window.
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam int CNT_W = $clog2(LAT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_wr_q, is_wr_d;

  logic                 cmd_ready_d;
  logic                 rsp_valid_d;
  logic [WSIZE*8-1:0]   rsp_rdata_d;
  logic                 en_d;
  logic [WSIZE-1:0]     we_d;
  logic [AWIDTH-1:0]    addr_d;
  logic [WSIZE*8-1:0]   di_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
    end
  end

  // Every output is a register loaded from its next-state value below.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      EN0       <= 1'b0;
      WE0       <= '0;
      A0        <= '0;
      Di0       <= '0;
    end else begin
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      EN0       <= en_d;
      WE0       <= we_d;
      A0        <= addr_d;
      Di0       <= di_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    cmd_ready_d = cmd_ready;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    en_d        = EN0;
    we_d        = WE0;
    addr_d      = A0;
    di_d        = Di0;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        en_d        = 1'b0;
        we_d        = '0;
        if (cmd_valid && cmd_ready) begin
          state_d     = ACCESS;
          cmd_ready_d = 1'b0;
          is_wr_d     = cmd_we;
          addr_d      = cmd_addr;
          di_d        = cmd_wdata;
          // An all-zero mask write is a no-op, so the RAM is never enabled.
          if (cmd_we) begin
            en_d = |cmd_mask;
            we_d = cmd_mask;
          end else begin
            en_d = 1'b1;
          end
        end
      end

      ACCESS: begin
        we_d = '0;
        if (is_wr_q) begin
          state_d     = IDLE;
          en_d        = 1'b0;
          cmd_ready_d = 1'b1;
        end else begin
          state_d = RD_WAIT;
          cnt_d   = CNT_INIT;
        end
      end

      RD_WAIT: begin
        if (cnt_q == CNT_ONE) begin
          state_d     = RSP;
          rsp_rdata_d = Do0;
          rsp_valid_d = 1'b1;
          en_d        = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
